dcache_write_buffer: RTL

Posted-write FIFO between the data cache memory port and the 4-port priority arbiter. It absorbs cache write-throughs so the processor does not wait on SRAM write latency, then drains them one word at a time through the arbiter's data-cache write slot. It gates data-cache memory reads whose word address matches a pending buffered write (read-after-write hazard), so SRAM is never read stale.

---
 rtl/dcache_write_buffer_pkg.sv | 22 ++
 rtl/dcache_write_buffer_if.sv | 51 +++++
 rtl/dcache_write_buffer_cam.sv | 23 ++
 rtl/dcache_write_buffer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dcache_write_buffer_pkg.sv
// Shared defaults, drain FSM encoding and sizing helpers for the data-cache
// posted-write buffer.
package dcache_write_buffer_pkg;

  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Byte-offset bits dropped when matching word addresses.
  localparam int WORD_OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } drain_state_e;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dcache_write_buffer_if.sv
// Bundle of cache-side, arbiter-side and status signals of the write buffer.
// The slave modport is the buffer; master is the cache/arbiter environment.
interface dcache_write_buffer_if
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = count_width(DEPTH);

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_be;
  logic                  wr_full;

  logic                  rd_req_in;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_req_out;
  logic                  rd_hazard;

  logic                  write_mem;
  logic                  grant_mem;
  logic                  ready_mem;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic                  mem_drive;

  logic                  flush;
  logic                  empty;
  logic [CNT_WIDTH-1:0]  count;

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_be, rd_req_in, rd_addr,
           grant_mem, ready_mem, flush,
    output wr_full, rd_req_out, rd_hazard, write_mem, mem_addr, mem_wdata,
           mem_be, mem_drive, empty, count
  );

  modport master (
    output wr_req, wr_addr, wr_data, wr_be, rd_req_in, rd_addr,
           grant_mem, ready_mem, flush,
    input  wr_full, rd_req_out, rd_hazard, write_mem, mem_addr, mem_wdata,
           mem_be, mem_drive, empty, count
  );

endinterface

// File: rtl/dcache_write_buffer_cam.sv
// DEPTH-way word-address comparator: flags every valid entry whose word
// address equals the incoming read address.
module dcache_write_buffer_cam
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] i_entry_addr,
  input  logic [DEPTH-1:0]                 i_valid,
  input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
  output logic [DEPTH-1:0]                 o_hit
);

  always_comb begin
    o_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit[i] = i_valid[i] &&
                 ((i_entry_addr[i] >> WORD_OFFSET_BITS) == (i_rd_addr >> WORD_OFFSET_BITS));
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted-write FIFO between the data cache and the arbiter's write slot; drains
// one word at a time and holds off reads that hit a pending write.
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  dcache_write_buffer_if.slave bus
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = count_width(DEPTH);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_COUNT  = CNT_WIDTH'(1);

  drain_state_e                    r_state, w_state_next;
  logic [PTR_WIDTH-1:0]            r_head, r_tail;
  logic [CNT_WIDTH-1:0]            r_count;
  logic [DEPTH-1:0]                r_valid;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] r_entry_addr;
  logic [DATA_WIDTH-1:0]           r_entry_data [DEPTH];
  logic [BE_WIDTH-1:0]             r_entry_be   [DEPTH];

  logic                            w_full, w_push, w_pop, w_pending, w_drain;
  logic                            w_last;
  logic [DEPTH-1:0]                w_hit;

  assign w_full    = (r_count == FULL_COUNT);
  assign w_push    = bus.wr_req & ~w_full;
  assign w_pending = (r_count != '0);
  // flush needs nothing of its own: any pending entry already drains.
  assign w_drain   = w_pending | (bus.flush & w_pending);
  // Popping the only entry with no refill empties the buffer.
  assign w_last    = (r_count == ONE_COUNT) & ~w_push;

  // NOTE: entry storage has no reset; r_valid alone decides whether an entry
  // means anything, so the payload RAM stays a plain clocked array.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_entry_addr[r_tail] <= bus.wr_addr;
      r_entry_data[r_tail] <= bus.wr_data;
      r_entry_be[r_tail]   <= bus.wr_be;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= r_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);
      if (w_push) begin
        r_tail          <= r_tail + PTR_WIDTH'(1);
        r_valid[r_tail] <= 1'b1;
      end
      if (w_pop) begin
        r_head          <= r_head + PTR_WIDTH'(1);
        r_valid[r_head] <= 1'b0;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a value held, which would infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    bus.write_mem = 1'b0;
    bus.mem_drive = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_drain) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        bus.write_mem = 1'b1;
        bus.mem_drive = bus.grant_mem;
        if (bus.grant_mem) begin
          if (bus.ready_mem) begin
            w_pop        = 1'b1;
            w_state_next = w_last ? ST_IDLE : ST_REQ;
          end else begin
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        bus.write_mem = 1'b1;
        bus.mem_drive = 1'b1;
        if (bus.ready_mem) begin
          w_pop        = 1'b1;
          w_state_next = w_last ? ST_IDLE : ST_REQ;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  dcache_write_buffer_cam #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cam (
    .i_entry_addr (r_entry_addr),
    .i_valid      (r_valid),
    .i_rd_addr    (bus.rd_addr),
    .o_hit        (w_hit)
  );

  assign bus.rd_hazard  = |w_hit;
  assign bus.rd_req_out = bus.rd_req_in & ~bus.rd_hazard;

  assign bus.mem_addr  = r_entry_addr[r_head];
  assign bus.mem_wdata = r_entry_data[r_head];
  assign bus.mem_be    = r_entry_be[r_head];

  assign bus.wr_full = w_full;
  assign bus.empty   = ~w_pending;
  assign bus.count   = r_count;

endmodule
